// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: X-stage sequencer for the shared multi-cycle mult/div unit.
// Define MULTDIV_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYC cycles.
module multdiv_issue_ctrl #(
    parameter int          TIMEOUT_CYC = 40,
    parameter logic [4:0]  CODE_MULT   = 5'd4,
    parameter logic [4:0]  CODE_DIV    = 5'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_is_div,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        exc_valid,
    output logic [4:0]  exc_code
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic        is_div_q, is_div_d, exc_q, exc_d;
`ifdef MULTDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;
`endif

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        is_div_d = is_div_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        // counter sits at zero outside WAIT, so it restarts on every entry
        cnt_d    = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
        timeout  = cnt_d == CW'(TIMEOUT_CYC);
`endif
        case (state_q)
            IDLE: if (op_valid && !flush) begin
                state_d  = START;
                op_a_d   = operand_a;
                op_b_d   = operand_b;
                is_div_d = op_is_div;
            end
            START: state_d = flush ? IDLE : WAIT;
            WAIT: if (flush) state_d = IDLE;
                else if (md_ready) begin
                    state_d  = DONE;
                    result_d = md_result;
                    exc_d    = md_exception;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (timeout) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end
`endif
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ctrl_MULT    = (state_q == START) && !is_div_q;
    assign ctrl_DIV     = (state_q == START) && is_div_q;
    assign md_op_a      = op_a_q;
    assign md_op_b      = op_b_q;
    assign stall        = ((state_q == IDLE) && op_valid && !flush) || (state_q == START) || (state_q == WAIT);
    // a flush landing on DONE kills the insn, so its result must not reach X/M
    assign result_valid = (state_q == DONE) && !flush;
    assign result       = result_q;
    assign exc_valid    = result_valid && exc_q;
    assign exc_code     = result_valid ? (is_div_q ? CODE_DIV : CODE_MULT) : 5'd0;
endmodule
